// File: rtl/serializer_pkg.sv
// serializer_pkg: shared sizing and FSM state type for the byte stream serializer
package serializer_pkg;
  localparam int DATA_W = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int BIT_W = $clog2(DATA_W);
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/byte_stream_serializer_if.sv
// byte_stream_serializer_if: byte push side, serial bit side and status of the serializer
interface byte_stream_serializer_if;
  import serializer_pkg::*;
  logic [DATA_W-1:0] in_data;
  logic in_valid;
  logic out_ready;
  logic out_bit;
  logic out_valid;
  logic out_first;
  logic full;
  logic [CNT_W-1:0] overflow_cnt;
  modport master (
    output in_data, in_valid, out_ready,
    input out_bit, out_valid, out_first, full, overflow_cnt
  );
  modport slave (
    input in_data, in_valid, out_ready,
    output out_bit, out_valid, out_first, full, overflow_cnt
  );
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: DEPTH-entry byte FIFO with occupancy count and registered full flag
module byte_fifo
  import serializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [OCC_W-1:0] count, countNext;
  assign countNext = count + OCC_W'(push) - OCC_W'(pop);
  assign rdData = mem[rdPtr];
  assign empty = count == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      full <= countNext == OCC_W'(DEPTH);
    end
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= wrData;
endmodule

// File: rtl/byte_stream_serializer.sv
// byte_stream_serializer: buffers pushed bytes and shifts them out MSB-first on a valid/ready bit stream,
// counting pushes dropped while the FIFO is full
module byte_stream_serializer
  import serializer_pkg::*;
(
  input logic clk,
  input logic rst,
  byte_stream_serializer_if.slave bus
);
  state_t state;
  logic [DATA_W-1:0] shiftReg, headData;
  logic [BIT_W-1:0] bitCnt;
  logic [CNT_W-1:0] ovfCnt;
  logic fifoFull, fifoEmpty, push, pop, accept, lastBit;
  assign accept = state == SHIFT && bus.out_ready;
  assign lastBit = accept && bitCnt == '0;
  // reload on the last accepted bit so consecutive bytes leave no bubble
  assign pop = !fifoEmpty && (state == IDLE || lastBit);
  assign push = bus.in_valid && (!fifoFull || pop);
  byte_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wrData(bus.in_data),
    .rdData(headData),
    .full(fifoFull),
    .empty(fifoEmpty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      shiftReg <= '0;
      bitCnt <= '0;
      ovfCnt <= '0;
    end else begin
      if (pop) begin
        shiftReg <= headData;
        bitCnt <= BIT_W'(DATA_W - 1);
        state <= SHIFT;
      end else if (accept) begin
        shiftReg <= {shiftReg[DATA_W-2:0], 1'b0};
        bitCnt <= bitCnt - 1'b1;
        state <= lastBit ? IDLE : SHIFT;
      end
      if (bus.in_valid && !push && ovfCnt != '1) ovfCnt <= ovfCnt + 1'b1;
    end
  assign bus.out_valid = state == SHIFT;
  assign bus.out_bit = shiftReg[DATA_W-1];
  assign bus.out_first = state == SHIFT && bitCnt == BIT_W'(DATA_W - 1);
  assign bus.full = fifoFull;
  assign bus.overflow_cnt = ovfCnt;
endmodule

// File: doc/byte_stream_serializer.md
Name: byte_stream_serializer

Overview:
- Sits directly downstream of the generated sequence core, which emits one 8-bit value per clock on its output byte.
- Buffers those bytes in a small FIFO and shifts each one out MSB-first, one bit per transfer, on a valid/ready bit stream.
- Counts bytes dropped while the FIFO is full, so the link can be checked for lossless operation.

Parameters:
- DATA_W, 8, width of an input byte and of the shift register.
- DEPTH, 4, number of FIFO entries (power of two, >= 2).
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  DATA_W  byte from the upstream sequence core.
- in_valid  in  1  push request; sampled on the rising edge of clk.
- out_ready  in  1  downstream accepts out_bit this cycle.
- out_bit  out  1  current serial bit.
- out_valid  out  1  out_bit is meaningful.
- out_first  out  1  high while out_bit is the MSB of a byte.
- full  out  1  FIFO occupancy == DEPTH.
- overflow_cnt  out  CNT_W  number of dropped pushes, saturating.

Behaviour:
- Reset (asynchronous, active-high, any time):
  - FIFO empty, pointers 0.
  - FSM to IDLE; shift register 0, bit counter 0.
  - out_valid=0, out_bit=0, out_first=0, full=0, overflow_cnt=0.
  - A byte in the middle of shifting is abandoned; no partial resume after reset.
- FIFO:
  - Push when in_valid and (not full, or a pop occurs in the same cycle).
  - Full with no pop: the push is dropped and overflow_cnt increments, holding at 2^CNT_W-1.
  - Simultaneous push and pop while empty: the byte goes through the FIFO (no bypass).
  - Pointers wrap modulo DEPTH. Occupancy is a log2(DEPTH)+1 bit count; full is registered from it.
- FSM states: IDLE, SHIFT.
  - IDLE: if FIFO non-empty, pop the head into the shift register, load bit counter with DATA_W-1, go to SHIFT. out_valid=0.
  - SHIFT: out_valid=1, out_bit=shift_reg[DATA_W-1], out_first=1 iff bit counter == DATA_W-1.
  - On out_valid and out_ready: shift left by one and decrement the counter.
  - On acceptance of the last bit (counter 0): if FIFO non-empty, pop and reload in the same edge and stay in SHIFT (no bubble); otherwise go to IDLE.
  - With out_ready low, out_bit, out_first and the counter hold indefinitely.
- Latency: a byte pushed at edge k into an empty FIFO with the FSM in IDLE gives out_valid=1 with its MSB after edge k+1.
- Throughput: 1 bit per cycle with out_ready held high.
  - The upstream core produces 1 byte per cycle, so its advance bit must gate in_valid.
  - Otherwise overflow is expected and counted.
- Capacity: DEPTH bytes in the FIFO plus one in the shift register.
- All outputs are registered or decoded directly from registered state; there is no combinational path from in_* to out_*.

Decomposition:
- Shared package serializer_pkg:
  - DATA_W, DEPTH, CNT_W defaults.
  - PTR_W = log2(DEPTH).
  - State enum {IDLE, SHIFT}.
- One sub-module, byte_fifo:
  - Storage, pointers, occupancy and full/empty.
  - Push and pop strobes, registered full.
- Top level: FSM, shift register, bit counter, overflow counter.

Test Plan:
- Reset, push 0xA5 once, out_ready=1 -> out_bit 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting one cycle after the push edge; out_first only on the first; out_valid=0 after.
- Push 0x01 then 0x80 on consecutive edges, out_ready=1 -> 16 contiguous valid bits 00000001 10000000, out_first at bits 0 and 8, no idle cycle between bytes.
- Push 0xF0, drop out_ready for 3 cycles after 2 bits accepted -> out_bit holds 1 for those 3 cycles; the full sequence is still 11110000, no bit lost or duplicated.
- out_ready=0, push 6 bytes on consecutive edges (DEPTH=4) -> first byte sits in the shift register, full=1 after the 5th push, 6th dropped, overflow_cnt=1. Then out_ready=1 -> the 5 retained bytes emerge in order.
- Hold full with in_valid=1 for 300 cycles -> overflow_cnt saturates at 255 and stays there.
- Assert rst mid-byte (after 3 bits, FIFO holding 2 bytes) -> out_valid, full and overflow_cnt go to 0 without a clock edge. After release, nothing is emitted until a new push.
